// File: rtl/kalman_pkg.sv
// Shared types and constants for the multi-channel 1D Kalman scheduler.
package kalman_pkg;

    localparam int STATE_BITS = 16;
    localparam int VAR_BITS   = 64;
    localparam int VAR_Q      = 30;

    typedef logic signed [STATE_BITS-1:0] state_t;
    typedef logic        [VAR_BITS-1:0]   var_t;

    localparam var_t P_INIT = var_t'(64'd1) << VAR_Q;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request strictly after ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req_i,
    input  logic [$clog2(N_CH)-1:0] ptr_i,
    output logic [N_CH-1:0]         grant_o,
    output logic [$clog2(N_CH)-1:0] grant_idx_o,
    output logic                    any_o
);

    localparam int IDX_W = $clog2(N_CH);

    // Scan the N_CH positions after ptr and keep the first requester.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % N_CH);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end else begin
                found = found;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/kalman_channel_scheduler.sv
// Time-shares one Kalman update engine across N_CH channels: captures samples,
// grants round-robin, writes results back to the x/P bank and streams estimates.
module kalman_channel_scheduler
    import kalman_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH-1:0]              z_valid,
    input  logic [N_CH*STATE_BITS-1:0]   z_data,
    input  logic [N_CH-1:0]              ch_init,
    output logic                         eng_start,
    output logic                         eng_abort,
    output state_t                       eng_x,
    output var_t                         eng_p,
    output state_t                       eng_z,
    input  logic                         eng_done,
    input  state_t                       eng_x_new,
    input  var_t                         eng_p_new,
    output state_t                       x_out,
    output logic [$clog2(N_CH)-1:0]      x_ch,
    output logic                         x_valid,
    output logic [15:0]                  drop_cnt,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int DW    = $clog2(N_CH + 1);

    sched_state_e      state_q, state_d;
    logic [N_CH-1:0]   pend_q;
    state_t            buf_q    [N_CH];
    state_t            x_bank_q [N_CH];
    var_t              p_bank_q [N_CH];
    logic [IDX_W-1:0]  ptr_q, gch_q;
    logic              kill_q, kill_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              eng_start_q, eng_abort_q, x_valid_q, timeout_err_q;
    state_t            eng_x_q, eng_z_q, x_out_q;
    var_t              eng_p_q;
    logic [IDX_W-1:0]  x_ch_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [N_CH-1:0]   arb_grant_s, drop_vec_s;
    logic [IDX_W-1:0]  arb_idx_s;
    logic              arb_any_s, grant_fire_s, done_fire_s, abort_fire_s, wb_en_s;
    logic [DW-1:0]     drop_num_s;
    logic [16:0]       drop_sum_s;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i       (pend_q),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant_s),
        .grant_idx_o (arb_idx_s),
        .any_o       (arb_any_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant/complete/abort events and the WAIT cycle counter.
    always_comb begin
        state_d      = state_q;
        grant_fire_s = 1'b0;
        done_fire_s  = 1'b0;
        abort_fire_s = 1'b0;
        wait_cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    state_d      = ISSUE;
                    grant_fire_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (eng_done) begin
                    state_d     = IDLE;
                    done_fire_s = 1'b1;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = IDLE;
                    abort_fire_s = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Kill tracking, writeback enable and saturating overwrite count.
    always_comb begin
        if (grant_fire_s) begin
            kill_d = ch_init[arb_idx_s];
        end else if (state_q != IDLE && ch_init[gch_q]) begin
            kill_d = 1'b1;
        end else begin
            kill_d = kill_q;
        end
        wb_en_s    = done_fire_s && !kill_q && !ch_init[gch_q];
        drop_num_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_vec_s[i] = z_valid[i] & pend_q[i] & ~ch_init[i] & ~(grant_fire_s & arb_grant_s[i]);
            drop_num_s    = drop_num_s + DW'(drop_vec_s[i]);
        end
        drop_sum_s = 17'(drop_cnt_q) + 17'(drop_num_s);
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
    end

    // Sample capture, channel bank, engine operand latch and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q        <= '0;
            ptr_q         <= '0;
            gch_q         <= '0;
            kill_q        <= 1'b0;
            wait_cnt_q    <= '0;
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            eng_x_q       <= '0;
            eng_p_q       <= '0;
            eng_z_q       <= '0;
            x_out_q       <= '0;
            x_ch_q        <= '0;
            x_valid_q     <= 1'b0;
            drop_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                buf_q[i]    <= '0;
                x_bank_q[i] <= '0;
                p_bank_q[i] <= P_INIT;
            end
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            kill_q      <= kill_d;
            eng_start_q <= grant_fire_s;
            eng_abort_q <= abort_fire_s;
            x_valid_q   <= wb_en_s;
            drop_cnt_q  <= drop_cnt_d;
            if (abort_fire_s) timeout_err_q <= 1'b1;
            if (grant_fire_s) begin
                ptr_q   <= arb_idx_s;
                gch_q   <= arb_idx_s;
                eng_x_q <= x_bank_q[arb_idx_s];
                eng_p_q <= p_bank_q[arb_idx_s];
                eng_z_q <= buf_q[arb_idx_s];
            end
            if (wb_en_s) begin
                x_out_q <= eng_x_new;
                x_ch_q  <= gch_q;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (ch_init[i]) begin
                    pend_q[i]   <= 1'b0;
                    x_bank_q[i] <= '0;
                    p_bank_q[i] <= P_INIT;
                end else begin
                    // A same-cycle grant already consumed the old buffer, so a new sample keeps pend set.
                    if (z_valid[i]) begin
                        buf_q[i]  <= z_data[i*STATE_BITS +: STATE_BITS];
                        pend_q[i] <= 1'b1;
                    end else if (grant_fire_s && arb_grant_s[i]) begin
                        pend_q[i] <= 1'b0;
                    end
                    if (wb_en_s && gch_q == IDX_W'(i)) begin
                        x_bank_q[i] <= eng_x_new;
                        p_bank_q[i] <= eng_p_new;
                    end
                end
            end
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_abort   = eng_abort_q;
    assign eng_x       = eng_x_q;
    assign eng_p       = eng_p_q;
    assign eng_z       = eng_z_q;
    assign x_out       = x_out_q;
    assign x_ch        = x_ch_q;
    assign x_valid     = x_valid_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_kalman_channel_scheduler.sv
// Scoreboard bench: mock engine (x+1, P/2, fixed latency) plus a transaction-level
// channel model; grants and estimates are checked as the DUT presents them.
module tb_kalman_channel_scheduler;
    import kalman_pkg::*;

    localparam int N_CH = 4;
    localparam int TO   = 256;
    localparam int LAT  = 10;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [N_CH-1:0]            z_valid = '0;
    logic [N_CH*STATE_BITS-1:0] z_data = '0;
    logic [N_CH-1:0]            ch_init = '0;
    logic                       eng_start, eng_abort, x_valid, timeout_err;
    state_t                     eng_x, eng_z, x_out;
    var_t                       eng_p;
    logic                       eng_done = 1'b0;
    state_t                     eng_x_new = '0;
    var_t                       eng_p_new = '0;
    logic [1:0]                 x_ch;
    logic [15:0]                drop_cnt;

    kalman_channel_scheduler #(.N_CH(N_CH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .z_valid(z_valid), .z_data(z_data), .ch_init(ch_init),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_x(eng_x), .eng_p(eng_p),
        .eng_z(eng_z), .eng_done(eng_done), .eng_x_new(eng_x_new), .eng_p_new(eng_p_new),
        .x_out(x_out), .x_ch(x_ch), .x_valid(x_valid), .drop_cnt(drop_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        state_t x;
        int     ch;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model of the channel bank, pending buffers and in-flight job
    state_t          m_x [N_CH];
    var_t            m_p [N_CH];
    state_t          m_buf [N_CH];
    logic [N_CH-1:0] m_pend = '0;
    int              m_ptr = 0, m_g = 0, m_start = 0, m_drop = 0;
    bit              m_busy = 0, m_kill = 0, m_terr = 0;
    // mock engine
    bit              e_busy = 0, hang = 0, spur_en = 0;
    int              e_cnt = 0;
    state_t          e_lx;
    var_t            e_lp;
    // inputs as they were during the previous cycle (i.e. sampled at the last edge)
    logic [N_CH-1:0]            p_zv = '0, p_init = '0;
    logic [N_CH*STATE_BITS-1:0] p_zd = '0;
    logic                       p_done = 1'b0, p_rst = 1'b0;
    state_t                     p_xn = '0;
    var_t                       p_pn = '0;
    // observations for directed checks
    int     last_start = 0, ls_ch = 0, xv_count = 0, abort_count = 0;
    state_t ls_x, ls_z;
    var_t   ls_p;
    int     grant_log[$];

    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (!p_rst) begin
                for (int i = 0; i < N_CH; i++) begin
                    m_x[i] = '0; m_p[i] = P_INIT; m_buf[i] = '0;
                end
                m_pend = '0; m_ptr = 0; m_busy = 0; m_kill = 0; m_drop = 0; m_terr = 0;
                sb.delete();
                chk("rst_ctl", {60'd0, eng_start, eng_abort, x_valid, timeout_err}, 64'd0);
                chk("rst_eng_x", 64'(eng_x), 64'd0);
                chk("rst_eng_p", eng_p, 64'd0);
                chk("rst_eng_z", 64'(eng_z), 64'd0);
                chk("rst_x_out", 64'(x_out), 64'd0);
                chk("rst_x_ch", 64'(x_ch), 64'd0);
                chk("rst_drop", 64'(drop_cnt), 64'd0);
            end else begin
                if (m_busy && p_init[m_g]) m_kill = 1;
                if (m_busy && p_done) begin
                    if (!m_kill) begin
                        m_x[m_g] = p_xn;
                        m_p[m_g] = p_pn;
                        e.x = p_xn; e.ch = m_g; e.cyc = m_start;
                        sb.push_back(e);
                    end
                    m_busy = 0;
                end
                if (eng_abort) begin
                    abort_count++;
                    chk("abort_in_flight", 64'(m_busy), 64'd1);
                    chk("abort_latency", 64'(cyc - m_start), 64'(TO + 1));
                    m_busy = 0;
                    m_terr = 1;
                end
                if (eng_start) begin
                    if (m_pend == '0) begin
                        chk("grant_without_pending", 64'd1, 64'd0);
                    end else begin
                        g = -1;
                        for (int k = 1; k <= N_CH; k++)
                            if (g < 0 && m_pend[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
                        chk("grant_x", 64'(eng_x), 64'(m_x[g]));
                        chk("grant_p", eng_p, m_p[g]);
                        chk("grant_z", 64'(eng_z), 64'(m_buf[g]));
                        m_pend[g] = 1'b0; m_ptr = g; m_g = g;
                        m_busy = 1; m_kill = 0; m_start = cyc;
                        grant_log.push_back(g);
                        last_start = cyc; ls_ch = g; ls_x = eng_x; ls_p = eng_p; ls_z = eng_z;
                    end
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (p_init[i]) begin
                        m_x[i] = '0; m_p[i] = P_INIT; m_pend[i] = 1'b0;
                        if (m_busy && m_g == i) m_kill = 1;
                    end else if (p_zv[i]) begin
                        if (m_pend[i] && m_drop < 65535) m_drop++;
                        m_buf[i]  = p_zd[i*STATE_BITS +: STATE_BITS];
                        m_pend[i] = 1'b1;
                    end
                end
                if (x_valid) begin
                    xv_count++;
                    if (sb.size() == 0) begin
                        chk("x_valid_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("x_out", 64'(x_out), 64'(e.x));
                        chk("x_ch", 64'(x_ch), 64'(e.ch));
                        chk("x_latency", 64'(cyc - e.cyc), 64'(LAT + 1));
                    end
                end
                chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
                chk("timeout_err", 64'(timeout_err), 64'(m_terr));
            end
            eng_done = 1'b0;
            if (!rst_n) begin
                e_busy = 0;
            end else if (eng_start) begin
                e_busy = 1; e_cnt = LAT; e_lx = eng_x; e_lp = eng_p;
            end else if (eng_abort) begin
                e_busy = 0;
            end else if (e_busy) begin
                if (!hang) begin
                    e_cnt--;
                    if (e_cnt == 0) begin
                        eng_done = 1'b1; eng_x_new = e_lx + 16'sd1; eng_p_new = e_lp >> 1;
                        e_busy = 0;
                    end
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                eng_done = 1'b1; eng_x_new = state_t'($urandom); eng_p_new = {$urandom, $urandom};
            end
            p_zv = z_valid; p_zd = z_data; p_init = ch_init; p_done = eng_done;
            p_xn = eng_x_new; p_pn = eng_p_new; p_rst = rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input state_t v);
        z_valid = '0;
        z_valid[ch] = 1'b1;
        z_data[ch*STATE_BITS +: STATE_BITS] = v;
        tick();
        z_valid = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        repeat (2) tick();
        while (!(m_pend == '0 && !m_busy && !e_busy && sb.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_idle_timeout"}, 64'd1, 64'd0);
        repeat (2) tick();
    endtask

    task automatic wait_busy(input int ch, input int budget);
        int n;
        n = 0;
        while (!(m_busy && m_g == ch) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_busy_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int k, xv0;
        int rr_exp[4];
        rr_exp = '{1, 2, 3, 0};
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single channel from a fresh bank
        k = cyc;
        send(2, 16'sd100);
        wait_idle("single", 100);
        chk("single_start_lat", 64'(last_start - k), 64'd2);
        chk("single_eng_x", 64'(ls_x), 64'd0);
        chk("single_eng_p", ls_p, 64'h40000000);
        chk("single_eng_z", 64'(ls_z), 64'd100);
        chk("single_ch", 64'(ls_ch), 64'd2);

        // fresh reset so the pointer starts at channel 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        grant_log.delete();
        xv0 = xv_count;
        z_data = {$urandom, $urandom};
        z_valid = '1;
        tick();
        z_valid = '0;
        wait_idle("rr", 200);
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("rr_order", 64'(grant_log[i]), 64'(rr_exp[i]));
        chk("rr_xvalid", 64'(xv_count - xv0), 64'd4);

        // overwrite while another channel is busy: newest wins, two drops
        send(0, state_t'($urandom));
        wait_busy(0, 20);
        send(1, 16'sd5);
        send(1, 16'sd6);
        send(1, 16'sd7);
        wait_idle("drop", 200);
        chk("drop_eng_z", 64'(ls_z), 64'd7);
        chk("drop_ch", 64'(ls_ch), 64'd1);
        chk("drop_total", 64'(drop_cnt), 64'd2);

        // engine never answers: abort, sticky error, bank left alone
        hang = 1;
        xv0 = xv_count;
        send(1, state_t'($urandom));
        wait_idle("timeout", 400);
        hang = 0;
        chk("timeout_abort_cnt", 64'(abort_count), 64'd1);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        chk("timeout_no_xvalid", 64'(xv_count - xv0), 64'd0);
        send(1, state_t'($urandom));
        wait_idle("after_timeout", 100);

        // re-initialise channel 3 while it is in flight
        send(3, state_t'($urandom));
        wait_busy(3, 20);
        repeat (3) tick();
        xv0 = xv_count;
        ch_init[3] = 1'b1;
        tick();
        ch_init = '0;
        wait_idle("reinit", 100);
        chk("reinit_no_xvalid", 64'(xv_count - xv0), 64'd0);
        send(3, state_t'($urandom));
        wait_idle("reinit_next", 100);
        chk("reinit_eng_x", 64'(ls_x), 64'd0);
        chk("reinit_eng_p", ls_p, 64'h40000000);

        // randomized traffic with sporadic re-inits and stray done pulses
        spur_en = 1;
        for (int i = 0; i < 500; i++) begin
            z_valid = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            z_data  = {$urandom, $urandom};
            ch_init = ($urandom_range(0, 31) == 0) ? N_CH'(1 << $urandom_range(0, N_CH - 1)) : '0;
            tick();
        end
        z_valid = '0;
        ch_init = '0;
        spur_en = 0;
        wait_idle("random", 600);

        // reset in the middle of WAIT with another sample pending
        send(0, state_t'($urandom));
        wait_busy(0, 20);
        send(1, state_t'($urandom));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_reset_drop", 64'(drop_cnt), 64'd0);
        chk("post_reset_terr", 64'(timeout_err), 64'd0);
        send(2, state_t'($urandom));
        wait_idle("post_reset", 100);
        chk("post_reset_ch", 64'(ls_ch), 64'd2);
        chk("post_reset_eng_x", 64'(ls_x), 64'd0);
        chk("post_reset_eng_p", ls_p, 64'h40000000);

        chk("final_scoreboard", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/kalman_channel_scheduler.md
Name: kalman_channel_scheduler

Overview:
- Shares one 1D Kalman update engine (A=1, H=1, fixed point) between N_CH sensor channels.
- Holds the per-channel state estimate x and variance P in a register bank.
- Buffers one pending measurement per channel and grants the engine round-robin.
- Writes engine results back to the bank and emits a channel-tagged estimate stream.
- Sits between the sensor front-ends and the engine, so the expensive divider exists only once.

Parameters:
- N_CH, 4, number of sensor channels (2..16).
- STATE_BITS, 16, signed width of measurement z and estimate x.
- VAR_BITS, 64, unsigned width of P.
- VAR_Q, 30, fractional bits of P. The initial P value is P_INIT = 1<<VAR_Q (1.0).
- TIMEOUT_CYC, 256, maximum number of WAIT cycles before the scheduler aborts the engine.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- z_valid  in  N_CH  per-channel measurement strobe.
- z_data  in  N_CH*STATE_BITS  measurements. Channel i occupies bits [i*STATE_BITS +: STATE_BITS].
- ch_init  in  N_CH  per-channel pulse that re-initialises that channel's state.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_abort  out  1  one-cycle abort pulse to the engine.
- eng_x  out  STATE_BITS  prior x of the granted channel.
- eng_p  out  VAR_BITS  prior P of the granted channel.
- eng_z  out  STATE_BITS  measurement of the granted channel.
- eng_done  in  1  engine result-valid pulse.
- eng_x_new  in  STATE_BITS  updated x from the engine.
- eng_p_new  in  VAR_BITS  updated P from the engine.
- x_out  out  STATE_BITS  updated estimate.
- x_ch  out  $clog2(N_CH)  channel id of x_out.
- x_valid  out  1  one-cycle pulse qualifying x_out and x_ch.
- drop_cnt  out  16  saturating count of overwritten measurements.
- timeout_err  out  1  sticky flag, set when the engine times out.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - all outputs to 0; FSM to IDLE; pend to 0.
  - x bank to 0; P bank to P_INIT.
  - round-robin pointer to channel 0; WAIT counter to 0.
  - The engine shares rst_n. Reset in the middle of an operation discards the in-flight update.
- Capture (every cycle, independent of FSM state):
  - z_valid[i]=1 writes buf[i]=z_data slice i and sets pend[i].
  - If pend[i] is already set and channel i is not granted this cycle: the new sample overwrites the old one (newest wins) and drop_cnt increments, saturating at 0xFFFF.
  - If channel i is granted in the same cycle as a new sample: the grant consumes the old buffer, the new sample is stored, pend[i] stays 1, and drop_cnt is unchanged.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, when any pend bit is set:
  - Selects channel g, the first set pend bit searching upward from ptr+1 modulo N_CH.
  - Latches eng_x=x[g], eng_p=P[g], eng_z=buf[g]; clears pend[g]; sets ptr=g; goes to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; go to WAIT. Minimum latency from z_valid to eng_start is 2 cycles.
- WAIT, on eng_done=1:
  - Writes x[g]=eng_x_new and P[g]=eng_p_new.
  - Next cycle: x_valid=1, x_out=eng_x_new, x_ch=g. FSM returns to IDLE.
  - Back-to-back grants are possible: the next ISSUE occurs 2 cycles after eng_done.
- WAIT timeout: the counter counts WAIT cycles. On reaching TIMEOUT_CYC without eng_done:
  - eng_abort=1 for one cycle; timeout_err is set (sticky until reset).
  - Bank is unchanged; no x_valid; the sample is lost (drop_cnt unchanged). FSM goes to IDLE.
- eng_done outside WAIT is ignored.
- ch_init[i]: x[i]=0, P[i]=P_INIT, pend[i]=0. It takes priority over a z_valid[i] in the same cycle.
  - If channel i is in flight, its writeback and x_valid are suppressed.
  - The FSM still completes WAIT normally.
- Width rules: the scheduler performs no arithmetic on x or P; values are stored and forwarded bit-exact.

Decomposition:
- Package kalman_pkg:
  - constants STATE_BITS, VAR_BITS, VAR_Q, P_INIT;
  - typedefs state_t (signed STATE_BITS) and var_t (unsigned VAR_BITS);
  - enum sched_state_e {IDLE, ISSUE, WAIT}.
- Sub-module rr_arbiter (N_CH): inputs req vector and ptr; outputs one-hot grant and grant index; purely combinational.

Test Plan:
- Single channel: with N_CH=4 and a mock engine of fixed latency 10 returning x+1 and P/2, drive z_valid[2]=1, z=100. Expect:
  - eng_start 2 cycles later with eng_x=0, eng_p=0x40000000, eng_z=100;
  - x_valid 11 cycles after eng_start with x_out=1, x_ch=2.
- Round-robin: assert z_valid on all 4 channels in one cycle. Expect grants in order 1,2,3,0 (ptr=0 after reset) and 4 x_valid pulses with x_ch 1,2,3,0.
- Drop: while ch0 is in WAIT, send 3 samples on ch1 (5, 6, 7). Expect eng_z=7 on ch1's grant and drop_cnt=2.
- Timeout: the mock engine never asserts eng_done (TIMEOUT_CYC=256). Expect:
  - eng_abort exactly 256 cycles into WAIT; timeout_err=1; no x_valid;
  - the channel's bank is unchanged on its next grant.
- Re-init in flight: pulse ch_init[3] while ch3 is in WAIT. Expect:
  - no x_valid on eng_done;
  - ch3's next grant shows eng_x=0, eng_p=0x40000000.
- Reset mid-WAIT: drop rst_n for 1 cycle. Expect all outputs 0, pend cleared, drop_cnt=0, timeout_err=0, and a clean grant of the first new sample.
